// File: rtl/byte_symbol_serializer.sv
// byte_symbol_serializer: pops bytes from a FIFO and emits them MSB-first as
// SYM_WIDTH-bit symbols with valid/ready handshake and frame-last marking.
`default_nettype none

module byte_symbol_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYM_WIDTH   = 2,
    parameter int FRAME_BYTES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_empty,
    output logic [SYM_WIDTH-1:0]  o_sym,
    output logic                  o_sym_valid,
    input  logic                  i_sym_ready,
    output logic                  o_last,
    output logic                  o_err
);

    localparam int SYMS  = DATA_WIDTH / SYM_WIDTH;
    localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SYMS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic                  xfer;
    logic                  sending;

    assign sending = (state_q == S_SEND);
    assign xfer    = sending & i_sym_ready;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        pop        = 1'b0;

        // Read data is only expected while a pop is outstanding.
        if (i_valid && (state_q != S_FETCH)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!i_empty) begin
                    pop     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_valid) begin
                    shreg_d = i_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    shreg_d = shreg_q << SYM_WIDTH;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0
                                                               : byte_cnt_q + CNT_W'(1);
                        // Chain straight into the next fetch to avoid an idle bubble.
                        if (!i_empty) begin
                            pop     = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

    // o_pop is combinational, so it is gated to stay low while reset is held.
    assign o_pop       = pop & rst;
    assign o_sym_valid = sending;
    assign o_sym       = sending ? shreg_q[DATA_WIDTH-1 -: SYM_WIDTH] : '0;
    assign o_last      = sending && (byte_cnt_q == LAST_BYTE) && (idx_q == LAST_IDX);
    assign o_err       = err_q;

endmodule

`default_nettype wire

// File: doc/byte_symbol_serializer.md
BYTE_SYMBOL_SERIALIZER -- requirements
Module: byte_symbol_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of bytes popped from the upstream fifo; SHALL be a multiple of SYM_WIDTH.
REQ-002 Parameter SYM_WIDTH, default 2: bits per output symbol (QPSK pair).
REQ-003 Parameter FRAME_BYTES, default 10: bytes per frame; o_last marks a frame's final symbol.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
REQ-006 o_pop  output  1  pop request to fifo; 1-cycle pulse.
REQ-007 i_data  input  DATA_WIDTH  fifo read data; valid when i_valid=1.
REQ-008 i_valid  input  1  fifo read-valid; arrives exactly one cycle after the o_pop pulse.
REQ-009 i_empty  input  1  fifo empty flag.
REQ-010 o_sym  output  SYM_WIDTH  current symbol.
REQ-011 o_sym_valid  output  1  o_sym holds a valid symbol.
REQ-012 i_sym_ready  input  1  downstream accepts; transfer = o_sym_valid & i_sym_ready on a rising edge.
REQ-013 o_last  output  1  qualifies o_sym as the final symbol of a frame.
REQ-014 o_err  output  1  sticky protocol error flag.

Function
REQ-015 FSM states IDLE, FETCH, SEND; reset state IDLE.
REQ-016 IDLE: if i_empty=0, assert o_pop for one cycle, go to FETCH; else stay, o_pop=0.
REQ-017 FETCH: o_pop=0; on i_valid=1 capture i_data into shift register, symbol index=0, go to SEND.
REQ-018 FETCH with i_valid=0: stay in FETCH; no timeout.
REQ-019 SEND: o_sym_valid=1; o_sym = shift register bits [DATA_WIDTH-1 -: SYM_WIDTH] (MSB pair first).
REQ-020 On transfer in SEND, shift left by SYM_WIDTH, increment symbol index.
REQ-021 o_sym and o_last SHALL hold stable while o_sym_valid=1 and i_sym_ready=0.
REQ-022 On transfer of the last symbol of a byte (index = DATA_WIDTH/SYM_WIDTH-1): if i_empty=0, assert o_pop that same cycle and go to FETCH; else go to IDLE.
REQ-023 Minimum latency: o_pop at cycle N, i_valid at N+1, first o_sym_valid at N+2.
REQ-024 Byte counter 0..FRAME_BYTES-1 increments when a byte's last symbol transfers; wraps to 0 after FRAME_BYTES-1.
REQ-025 o_last=1 only in SEND, when byte counter = FRAME_BYTES-1 and symbol index = last.
REQ-026 o_sym_valid=0 in IDLE and FETCH; o_sym is don't-care there but driven to 0.
REQ-027 i_valid=1 in IDLE or SEND sets o_err=1; the data is discarded and the state is unchanged.
REQ-028 o_err clears only on reset.
REQ-029 o_pop SHALL never assert while i_empty=1 or while a pop is outstanding (FETCH).
REQ-030 i_sym_ready has no effect outside SEND; the block never drops or duplicates a symbol.

Reset
REQ-031 rst=0 forces: state IDLE, o_pop=0, o_sym=0, o_sym_valid=0, o_last=0, o_err=0, byte counter=0, symbol index=0, shift register=0.
REQ-032 rst asserted mid-byte or mid-frame abandons the partial byte/frame; after release the next byte is frame byte 0.
REQ-033 A pop outstanding at reset is lost; an i_valid in the first cycle after release sets o_err.

Verification
REQ-034 i_empty=0 with byte 0xB4, i_sym_ready=1 -> o_pop pulse, then o_sym 2,3,1,0 on 4 consecutive cycles, then IDLE.
REQ-035 10 bytes 0x00..0x09 back-to-back, ready=1 -> 40 symbols, o_last only on symbol 40 (value 1); 11th byte's first symbol has o_last=0.
REQ-036 Byte 0xE1 with i_sym_ready toggling 1,0,0,1,0,1,1 -> symbols 3,2,0,1 each held stable while ready=0; no loss, no repeat.
REQ-037 i_empty=1 throughout -> o_pop never asserts, o_sym_valid stays 0 for 50 cycles.
REQ-038 rst=0 after 2 symbols of frame byte 5 -> all outputs 0 immediately; next byte's last symbol has o_last=1 only after 10 further bytes.
REQ-039 i_valid pulse while in IDLE -> o_err=1 and held until reset; serialization of subsequent bytes is unaffected.
